// File: rtl/seq_loop_engine_if.sv
// Handshake and result bundle for seq_loop_engine; master drives the control
// side, slave is the loop engine itself.
interface seq_loop_engine_if #(
    parameter int DATA_W   = 8,
    parameter int SEQ_LEN  = 3,
    parameter int ITER_W   = 8,
    parameter int CHANNELS = 2
);
    logic                         start;
    logic [ITER_W-1:0]            iter_cnt;
    logic [CHANNELS*DATA_W-1:0]   step;
    logic                         hold;
    logic                         abort;
    logic                         busy;
    logic                         done;
    logic [CHANNELS*DATA_W-1:0]   acc;
    logic [ITER_W-1:0]            iter;
    logic [SEQ_LEN-1:0]           seq_state;
    logic [CHANNELS-1:0]          ovf;

    modport master (
        output start, iter_cnt, step, hold, abort,
        input  busy, done, acc, iter, seq_state, ovf
    );

    modport slave (
        input  start, iter_cnt, step, hold, abort,
        output busy, done, acc, iter, seq_state, ovf
    );
endinterface

// File: rtl/seq_loop_engine.sv
// Counted-loop sequencer: ITER passes over a SEQ_LEN one-hot chain, adding a
// latched per-channel step to each accumulator at the end of every pass.
module seq_loop_engine #(
    parameter int DATA_W   = 8,
    parameter int SEQ_LEN  = 3,
    parameter int ITER_W   = 8,
    parameter int CHANNELS = 2,
    parameter int SATURATE = 0
) (
    input logic clk,
    input logic rst,
    seq_loop_engine_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                 state;
    logic [SEQ_LEN-1:0]         seq_q;
    logic [ITER_W-1:0]          iter_q;
    logic [ITER_W-1:0]          count_q;
    logic [CHANNELS*DATA_W-1:0] step_q;
    logic [CHANNELS*DATA_W-1:0] acc_q;
    logic [CHANNELS-1:0]        ovf_q;

    logic [CHANNELS*DATA_W-1:0] acc_nxt;
    logic [CHANNELS-1:0]        ovf_nxt;
    logic [DATA_W:0]            sum;
    logic [ITER_W-1:0]          iter_inc;
    logic                       last;

    assign last     = seq_q[SEQ_LEN-1];
    assign iter_inc = iter_q + ITER_W'(1);

    // Carry out of the widened sum drives both the sticky flag and the clamp.
    always_comb begin
        acc_nxt = acc_q;
        ovf_nxt = ovf_q;
        sum     = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            sum = {1'b0, acc_q[c*DATA_W +: DATA_W]} + {1'b0, step_q[c*DATA_W +: DATA_W]};
            if (sum[DATA_W]) begin
                ovf_nxt[c] = 1'b1;
            end
            if (SATURATE != 0 && sum[DATA_W]) begin
                acc_nxt[c*DATA_W +: DATA_W] = '1;
            end else begin
                acc_nxt[c*DATA_W +: DATA_W] = sum[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            seq_q   <= '0;
            iter_q  <= '0;
            count_q <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        count_q <= bus.iter_cnt;
                        step_q  <= bus.step;
                        acc_q   <= '0;
                        iter_q  <= '0;
                        ovf_q   <= '0;
                        if (bus.iter_cnt != '0) begin
                            state <= S_RUN;
                            seq_q <= SEQ_LEN'(1);
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // Abort outranks hold and discards any add due this edge.
                    if (bus.abort) begin
                        state <= S_IDLE;
                        seq_q <= '0;
                    end else if (!bus.hold) begin
                        if (last) begin
                            acc_q  <= acc_nxt;
                            ovf_q  <= ovf_nxt;
                            iter_q <= iter_inc;
                            if (iter_inc == count_q) begin
                                state <= S_DONE;
                                seq_q <= '0;
                            end else begin
                                seq_q <= SEQ_LEN'(1);
                            end
                        end else begin
                            seq_q <= seq_q << 1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (state == S_RUN);
    assign bus.done      = (state == S_DONE);
    assign bus.acc       = acc_q;
    assign bus.iter      = iter_q;
    assign bus.seq_state = seq_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_loop_engine.sv
// Bench for seq_loop_engine: three configurations share one stimulus stream and
// are compared every cycle against an arithmetic model of elapsed run cycles.
module tb_seq_loop_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  iter_cnt = '0;
    logic [31:0] step_bus = '0;
    logic        hold = 1'b0;
    logic        abort = 1'b0;

    always #5 clk = ~clk;

    seq_loop_engine_if #(.DATA_W(8), .SEQ_LEN(3), .ITER_W(8), .CHANNELS(2)) ifa ();
    seq_loop_engine_if #(.DATA_W(8), .SEQ_LEN(3), .ITER_W(8), .CHANNELS(2)) ifb ();
    seq_loop_engine_if #(.DATA_W(8), .SEQ_LEN(1), .ITER_W(8), .CHANNELS(4)) ifc ();

    assign ifa.start = start;  assign ifb.start = start;  assign ifc.start = start;
    assign ifa.iter_cnt = iter_cnt;  assign ifb.iter_cnt = iter_cnt;  assign ifc.iter_cnt = iter_cnt;
    assign ifa.step = step_bus[15:0];  assign ifb.step = step_bus[15:0];  assign ifc.step = step_bus;
    assign ifa.hold = hold;  assign ifb.hold = hold;  assign ifc.hold = hold;
    assign ifa.abort = abort;  assign ifb.abort = abort;  assign ifc.abort = abort;

    seq_loop_engine #(.DATA_W(8), .SEQ_LEN(3), .ITER_W(8), .CHANNELS(2), .SATURATE(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_loop_engine #(.DATA_W(8), .SEQ_LEN(3), .ITER_W(8), .CHANNELS(2), .SATURATE(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_loop_engine #(.DATA_W(8), .SEQ_LEN(1), .ITER_W(8), .CHANNELS(4), .SATURATE(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    logic        o_busy [3];
    logic        o_done [3];
    logic [31:0] o_acc  [3];
    logic [31:0] o_iter [3];
    logic [31:0] o_seq  [3];
    logic [31:0] o_ovf  [3];

    assign o_busy[0] = ifa.busy;  assign o_busy[1] = ifb.busy;  assign o_busy[2] = ifc.busy;
    assign o_done[0] = ifa.done;  assign o_done[1] = ifb.done;  assign o_done[2] = ifc.done;
    assign o_acc[0]  = {16'b0, ifa.acc};  assign o_acc[1] = {16'b0, ifb.acc};  assign o_acc[2] = ifc.acc;
    assign o_iter[0] = {24'b0, ifa.iter}; assign o_iter[1] = {24'b0, ifb.iter}; assign o_iter[2] = {24'b0, ifc.iter};
    assign o_seq[0]  = {29'b0, ifa.seq_state}; assign o_seq[1] = {29'b0, ifb.seq_state}; assign o_seq[2] = {31'b0, ifc.seq_state};
    assign o_ovf[0]  = {30'b0, ifa.ovf};  assign o_ovf[1] = {30'b0, ifb.ovf};  assign o_ovf[2] = {28'b0, ifc.ovf};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, inst, act, want, $time);
        end
    endtask

    // Model: a run is just a count of elapsed non-held cycles; everything
    // visible follows from that count, the latched length and the steps.
    int seqlen [3] = '{3, 3, 1};
    int chn    [3] = '{2, 2, 4};
    int sat    [3] = '{0, 1, 0};
    int ph     [3];
    int cyc    [3];
    int cnt    [3];
    int stp    [3][4];
    bit valid = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                ph[i] = 0; cyc[i] = 0; cnt[i] = 0;
                for (int c = 0; c < 4; c++) stp[i][c] = 0;
            end else if (ph[i] == 0) begin
                if (start) begin
                    cnt[i] = int'(iter_cnt);
                    cyc[i] = 0;
                    for (int c = 0; c < 4; c++)
                        stp[i][c] = (c < chn[i]) ? int'(step_bus[c*8 +: 8]) : 0;
                    ph[i] = (iter_cnt == 0) ? 2 : 1;
                end
            end else if (ph[i] == 1) begin
                if (abort) ph[i] = 0;
                else if (!hold) begin
                    cyc[i]++;
                    if (cyc[i] == cnt[i] * seqlen[i]) ph[i] = 2;
                end
            end else begin
                ph[i] = 0;
            end
        end
        if (rst) valid = 1;
    end

    always @(negedge clk) begin
        if (valid) begin
            for (int i = 0; i < 3; i++) begin
                int it, prod, a;
                logic [31:0] e_acc, e_ovf, e_seq;
                it = cyc[i] / seqlen[i];
                e_acc = '0; e_ovf = '0;
                for (int c = 0; c < chn[i]; c++) begin
                    prod = it * stp[i][c];
                    if (sat[i] != 0) a = (prod > 255) ? 255 : prod;
                    else a = prod % 256;
                    e_acc = e_acc | (32'(a) << (c * 8));
                    if (prod > 255) e_ovf = e_ovf | (32'd1 << c);
                end
                e_seq = (ph[i] == 1) ? (32'd1 << (cyc[i] % seqlen[i])) : 32'd0;
                chk("busy", i, {31'b0, o_busy[i]}, {31'b0, ph[i] == 1});
                chk("done", i, {31'b0, o_done[i]}, {31'b0, ph[i] == 2});
                chk("acc",  i, o_acc[i],  e_acc);
                chk("iter", i, o_iter[i], 32'(it));
                chk("seq_state", i, o_seq[i], e_seq);
                chk("ovf",  i, o_ovf[i],  e_ovf);
            end
        end
    end

    int busy_cnt [3];
    int done_cnt [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_busy[i]) busy_cnt[i]++;
            if (o_done[i]) done_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        iter_cnt = 8'(n);
        for (int i = 0; i < 3; i++) begin busy_cnt[i] = 0; done_cnt[i] = 0; end
        tick();
        start = 1'b0;
        iter_cnt = 8'($urandom);
        step_bus = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && (ifa.busy || ifa.done || ifb.busy || ifb.done || ifc.busy || ifc.done)) begin
            tick();
            k++;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL wait_idle timeout got=busy want=idle t=%0t", $time);
        end
    endtask

    logic [2:0] s0;

    initial begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_acc", 0, o_acc[0], 32'd0);
        chk("reset_busy", 0, {31'b0, o_busy[0]}, 32'd0);
        chk("reset_seq", 0, o_seq[0], 32'd0);

        // 8 iterations of step 3 on ch0
        step_bus = 32'h0000_0003;
        do_start(8);
        repeat (7) tick();
        chk("mid_acc", 0, o_acc[0], 32'h0000_0006);
        chk("mid_iter", 0, o_iter[0], 32'd2);
        wait_idle(100);
        chk("t1_acc", 0, o_acc[0], 32'h0000_0018);
        chk("t1_iter", 0, o_iter[0], 32'd8);
        chk("t1_ovf", 0, o_ovf[0], 32'd0);
        chk("t1_busy_cycles", 0, 32'(busy_cnt[0]), 32'd24);
        chk("t1_done_pulses", 0, 32'(done_cnt[0]), 32'd1);

        // zero-length loop
        do_start(0);
        chk("t2_done", 0, {31'b0, o_done[0]}, 32'd1);
        tick();
        chk("t2_busy_cycles", 0, 32'(busy_cnt[0]), 32'd0);
        chk("t2_acc", 0, o_acc[0], 32'd0);

        // overflow: wrap vs saturate
        step_bus = 32'h0000_0064;
        do_start(3);
        step_bus = $urandom;
        wait_idle(100);
        chk("t3_wrap_acc", 0, {24'b0, o_acc[0][7:0]}, 32'd44);
        chk("t3_wrap_ovf", 0, {31'b0, o_ovf[0][0]}, 32'd1);
        chk("t3_sat_acc", 1, {24'b0, o_acc[1][7:0]}, 32'd255);
        chk("t3_sat_ovf", 1, {31'b0, o_ovf[1][0]}, 32'd1);

        // hold for 5 cycles mid-run
        step_bus = 32'h0000_0001;
        do_start(4);
        repeat (3) tick();
        hold = 1'b1;
        s0 = o_seq[0][2:0];
        repeat (5) begin
            tick();
            chk("t4_seq_frozen", 0, {29'b0, o_seq[0][2:0]}, {29'b0, s0});
        end
        hold = 1'b0;
        wait_idle(100);
        chk("t4_busy_cycles", 0, 32'(busy_cnt[0]), 32'd17);
        chk("t4_acc", 0, {24'b0, o_acc[0][7:0]}, 32'd4);

        // abort sampled at the 7th run edge
        step_bus = 32'h0000_0002;
        do_start(10);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", 0, {31'b0, o_busy[0]}, 32'd0);
        chk("t5_acc", 0, {24'b0, o_acc[0][7:0]}, 32'd4);
        chk("t5_iter", 0, o_iter[0], 32'd2);
        repeat (3) tick();
        chk("t5_no_done", 0, 32'(done_cnt[0]), 32'd0);
        step_bus = 32'h0000_0002;
        do_start(1);
        wait_idle(100);
        chk("t5_rerun_acc", 0, {24'b0, o_acc[0][7:0]}, 32'd2);

        // four-channel single-state chain, then reset mid-run
        step_bus = 32'h0403_0201;
        do_start(5);
        wait_idle(100);
        chk("t6_acc4", 2, o_acc[2], 32'h140F_0A05);
        chk("t6_busy_cycles", 2, 32'(busy_cnt[2]), 32'd5);
        chk("t6_acc_a", 0, o_acc[0], 32'h0000_0A05);
        step_bus = 32'h0403_0201;
        do_start(5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_acc", 2, o_acc[2], 32'd0);
        chk("t6_rst_busy", 2, {31'b0, o_busy[2]}, 32'd0);
        chk("t6_rst_iter", 2, o_iter[2], 32'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 5) == 0);
            iter_cnt = 8'($urandom_range(0, 6));
            step_bus = $urandom;
            hold     = ($urandom_range(0, 4) == 0);
            abort    = ($urandom_range(0, 24) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
        wait_idle(200);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_loop_engine.md
Name: seq_loop_engine

Overview:
- Parametrised counted-loop sequencer: runs ITER iterations of a SEQ_LEN-state one-hot chain and adds a per-channel step to each channel accumulator at the end of every iteration.
- Successor to the fixed 3-state, single-accumulator sequencing tops. Adds variable width, variable depth, multiple channels, a start/done handshake, hold, abort, and wrap/saturate overflow handling.
- Sits under the generated top as a reusable loop controller.

Parameters:
- DATA_W, 8, accumulator and step width per channel.
- SEQ_LEN, 3, states per iteration; must be ≥1.
- ITER_W, 8, width of the iteration count.
- CHANNELS, 2, number of independent accumulators.
- SATURATE, 0: 0 means accumulators wrap modulo 2^DATA_W; 1 means they clamp at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- iter_cnt  input  ITER_W  iteration count; latched on an accepted start.
- step  input  CHANNELS*DATA_W  per-channel increments, channel 0 in the LSBs; latched on an accepted start.
- hold  input  1  freezes all RUN-state registers for that cycle.
- abort  input  1  cancels the loop.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on normal completion.
- acc  output  CHANNELS*DATA_W  accumulators, channel 0 in the LSBs.
- iter  output  ITER_W  completed iterations.
- seq_state  output  SEQ_LEN  one-hot current sequence state; all-zero outside RUN.
- ovf  output  CHANNELS  per-channel sticky overflow flag.

Behaviour:
- Reset (rst high at an edge): state=IDLE, busy=0, done=0, acc=0, iter=0, seq_state=0, ovf=0, latched registers=0. rst has priority over every other input.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E:
  - Latch iter_cnt and step.
  - Clear acc, iter and ovf.
  - If iter_cnt≠0: go to RUN with seq_state=1 (bit 0), busy=1 after E.
  - If iter_cnt=0: go to DONE directly; done=1 after E.
  - start while in RUN or DONE is ignored.
- RUN, each edge with hold=0, abort=0:
  - If seq_state bit k < SEQ_LEN-1: shift to bit k+1.
  - If at bit SEQ_LEN-1 (last state): every channel updates acc += step; iter increments; seq_state returns to bit 0.
  - If the incremented iter equals the latched count: go to DONE and seq_state=0.
  - SEQ_LEN=1 means every RUN cycle is a last state.
- Latency: a start accepted at edge E with count N≥1 gives the final add at edge E+N*SEQ_LEN. busy is high for exactly N*SEQ_LEN cycles. done is high for the single cycle after the final add.
- DONE: done=1 and busy=0 for one cycle, then IDLE unconditionally. hold and abort are ignored in DONE.
- Results: acc, iter and ovf keep their values after DONE until the next accepted start or reset.
- Arithmetic: each channel computes a (DATA_W+1)-bit sum.
  - On carry out, set that channel's ovf bit; it stays set until the next accepted start or reset.
  - SATURATE=0: acc takes the low DATA_W bits.
  - SATURATE=1: acc takes all-ones on carry.
- hold=1 in RUN: no register changes; busy stays 1.
- abort=1 in RUN: go to IDLE at that edge, even if it is the last state and even if hold=1. No add occurs, no done pulse, busy=0 and seq_state=0 after the edge, acc/iter/ovf frozen at their pre-abort values.
- Simultaneous start and abort in IDLE: the start is accepted and abort is ignored.
- Step and iter_cnt inputs may change freely after acceptance. Only the latched copies are used.

Test Plan:
- Default parameters; rst for 1 cycle; start with iter_cnt=8, step={ch1=0, ch0=3} → busy high for 24 cycles; done pulses for 1 cycle; then acc ch0=24, ch1=0, iter=8, ovf=0. After 7 cycles from start: acc ch0=6, iter=2.
- iter_cnt=0 → done high in the cycle after start; busy never asserted; acc=0.
- SATURATE=0, iter_cnt=3, step ch0=100 → acc ch0=44, ovf[0]=1. SATURATE=1 with the same stimulus → acc ch0=255, ovf[0]=1.
- iter_cnt=4, step ch0=1, hold high for 5 cycles mid-run → busy lasts 17 cycles; final acc ch0=4; seq_state frozen during hold.
- iter_cnt=10, step ch0=2, abort asserted at cycle 7 of RUN → IDLE next edge; acc ch0=4, iter=2, no done pulse. A following start with iter_cnt=1 → acc ch0=2.
- SEQ_LEN=1, CHANNELS=4, iter_cnt=5, steps {1,2,3,4} → busy 5 cycles; acc {5,10,15,20}. rst asserted at RUN cycle 2 of a rerun → all outputs 0 next edge.
